// File: rtl/vec_wb_pkg.sv
// -----------------------------------------------------------------------------
// vec_wb_pkg
// Shared definitions for the vector register-file write-back path: register
// file geometry, one-hot LMUL encodings, write-back FSM states and request
// source identifiers. Also used alongside the vec_regfile defines.
// -----------------------------------------------------------------------------
package vec_wb_pkg;

  localparam int VLEN       = 512;
  localparam int NUM_REGS   = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 8 * VLEN;

  localparam logic [3:0] LMUL_1 = 4'b0001;
  localparam logic [3:0] LMUL_2 = 4'b0010;
  localparam logic [3:0] LMUL_4 = 4'b0100;
  localparam logic [3:0] LMUL_8 = 4'b1000;

  typedef enum logic {
    IDLE,
    WR
  } wb_state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_EXE  = 2'b01,
    SRC_LSU  = 2'b10,
    SRC_MASK = 2'b11
  } wb_src_e;

  // Number of registers in the group for a one-hot LMUL, 0 for any other code.
  function automatic logic [3:0] lmul_size(input logic [3:0] lmul);
    logic [3:0] size;
    unique case (lmul)
      LMUL_1:  size = 4'd1;
      LMUL_2:  size = 4'd2;
      LMUL_4:  size = 4'd4;
      LMUL_8:  size = 4'd8;
      default: size = 4'd0;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/vec_wb_align_chk.sv
// -----------------------------------------------------------------------------
// vec_wb_align_chk
// Combinational legality check of a register-group write destination.
// A request is legal when LMUL is one-hot (1/2/4/8), the base address is a
// multiple of the group size and the whole group lies inside the file.
//
// Ports:
//   i_addr  [ADDR_W-1:0]  destination base register
//   i_lmul  [3:0]         one-hot LMUL
//   o_legal               1 when the (addr, lmul) pair may be written
// -----------------------------------------------------------------------------
module vec_wb_align_chk
  import vec_wb_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int N_REGS = NUM_REGS
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [3:0]        i_lmul,
  output logic              o_legal
);

  localparam int AW1 = ADDR_W + 1;

  logic [3:0]        w_size;
  logic [ADDR_W-1:0] w_low_mask;
  logic [AW1-1:0]    w_end;
  logic              w_onehot;
  logic              w_aligned;
  logic              w_fits;

  always_comb begin
    w_size     = lmul_size(i_lmul);
    w_onehot   = (w_size != 4'd0);
    // Group sizes are powers of two, so alignment is a test of the low bits.
    w_low_mask = ADDR_W'(w_size) - ADDR_W'(1);
    w_aligned  = ((i_addr & w_low_mask) == '0);
    // One extra bit so that addr + LMUL == N_REGS does not wrap.
    w_end      = {1'b0, i_addr} + AW1'(w_size);
    w_fits     = (w_end <= AW1'(N_REGS));
    o_legal    = w_onehot & w_aligned & w_fits;
  end

endmodule

// File: rtl/vec_wb_arbiter.sv
// -----------------------------------------------------------------------------
// vec_wb_arbiter
// Write-back arbiter/sequencer for the single write port of vec_regfile.
// Grants one of mask / EXE / LSU per cycle (mask first), checks the LMUL
// group alignment of EXE/LSU writes and drives the register-file write port
// from a registered output stage one cycle after the grant. Illegal requests
// are consumed without a write and reported through err_valid/err_src and a
// saturating err_count.
//
// Build option:
//   VEC_WB_ARB_RR_EN defined   : EXE/LSU round-robin, pointer resets to EXE.
//   VEC_WB_ARB_RR_EN undefined : fixed priority mask > LSU > EXE.
//
// Ports:
//   clk, reset (async, active-low)
//   exe_valid/exe_ready/exe_addr/exe_data/exe_lmul  EXE write request
//   lsu_valid/lsu_ready/lsu_addr/lsu_data/lsu_lmul  LSU write request
//   mask_valid/mask_ready/mask_data                 v0 mask update
//   rf_busy                                         no grant this cycle
//   wr_en/waddr/wdata/wr_lmul/mask_wr_en            register-file write port
//   err_valid/err_src/err_count                     illegal-request reporting
// -----------------------------------------------------------------------------
module vec_wb_arbiter
  import vec_wb_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  exe_valid,
  output logic                  exe_ready,
  input  logic [ADDR_WIDTH-1:0] exe_addr,
  input  logic [DATA_WIDTH-1:0] exe_data,
  input  logic [3:0]            exe_lmul,

  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic [3:0]            lsu_lmul,

  input  logic                  mask_valid,
  output logic                  mask_ready,
  input  logic [VLEN-1:0]       mask_data,

  input  logic                  rf_busy,

  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [3:0]            wr_lmul,
  output logic                  mask_wr_en,

  output logic                  err_valid,
  output logic [1:0]            err_src,
  output logic [ERR_CNT_W-1:0]  err_count
);

  wb_state_e             r_state;
  wb_state_e             w_state_nxt;
  wb_src_e               w_gnt;

  logic                  w_exe_legal;
  logic                  w_lsu_legal;
  logic                  w_gnt_legal;
  logic                  w_gnt_illegal;
  logic                  w_can_grant;
  logic                  w_pick_lsu;

  logic                  w_nxt_is_mask;
  logic [ADDR_WIDTH-1:0] w_nxt_waddr;
  logic [DATA_WIDTH-1:0] w_nxt_wdata;
  logic [3:0]            w_nxt_lmul;

  logic                  r_is_mask;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_wr_lmul;
  logic                  r_err_valid;
  logic [1:0]            r_err_src;
  logic [ERR_CNT_W-1:0]  r_err_count;

`ifdef VEC_WB_ARB_RR_EN
  logic                  r_pref_lsu;
`endif

  vec_wb_align_chk #(
    .ADDR_W (ADDR_WIDTH),
    .N_REGS (NUM_REGS)
  ) u_exe_chk (
    .i_addr  (exe_addr),
    .i_lmul  (exe_lmul),
    .o_legal (w_exe_legal)
  );

  vec_wb_align_chk #(
    .ADDR_W (ADDR_WIDTH),
    .N_REGS (NUM_REGS)
  ) u_lsu_chk (
    .i_addr  (lsu_addr),
    .i_lmul  (lsu_lmul),
    .o_legal (w_lsu_legal)
  );

  // Grant selection. Readies are gated by reset so nothing is accepted
  // while the output stage is held cleared.
  always_comb begin
    w_gnt       = SRC_NONE;
    w_can_grant = reset & ~rf_busy;
`ifdef VEC_WB_ARB_RR_EN
    w_pick_lsu  = lsu_valid & (~exe_valid | r_pref_lsu);
`else
    w_pick_lsu  = lsu_valid;
`endif
    if (w_can_grant) begin
      if (mask_valid) begin
        w_gnt = SRC_MASK;
      end else if (w_pick_lsu) begin
        w_gnt = SRC_LSU;
      end else if (exe_valid) begin
        w_gnt = SRC_EXE;
      end
    end
  end

  assign exe_ready  = (w_gnt == SRC_EXE);
  assign lsu_ready  = (w_gnt == SRC_LSU);
  assign mask_ready = (w_gnt == SRC_MASK);

  // Legality of the granted request and the payload it would load.
  always_comb begin
    w_gnt_legal   = 1'b0;
    w_gnt_illegal = 1'b0;
    w_nxt_is_mask = 1'b0;
    w_nxt_waddr   = exe_addr;
    w_nxt_wdata   = exe_data;
    w_nxt_lmul    = exe_lmul;
    unique case (w_gnt)
      SRC_EXE: begin
        w_gnt_legal   = w_exe_legal;
        w_gnt_illegal = ~w_exe_legal;
      end
      SRC_LSU: begin
        w_gnt_legal   = w_lsu_legal;
        w_gnt_illegal = ~w_lsu_legal;
        w_nxt_waddr   = lsu_addr;
        w_nxt_wdata   = lsu_data;
        w_nxt_lmul    = lsu_lmul;
      end
      SRC_MASK: begin
        w_gnt_legal   = 1'b1;
        w_nxt_is_mask = 1'b1;
        w_nxt_waddr   = '0;
        w_nxt_wdata   = {{(DATA_WIDTH - VLEN){1'b0}}, mask_data};
        w_nxt_lmul    = LMUL_1;
      end
      default: ;
    endcase
  end

  // Write-back FSM: WR means the output stage holds a write this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = IDLE;
    unique case (r_state)
      IDLE:    if (w_gnt_legal) w_state_nxt = WR;
      WR:      if (w_gnt_legal) w_state_nxt = WR;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output stage payload, loaded only on a legal grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_is_mask <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wr_lmul <= '0;
    end else if (w_gnt_legal) begin
      r_is_mask <= w_nxt_is_mask;
      r_waddr   <= w_nxt_waddr;
      r_wdata   <= w_nxt_wdata;
      r_wr_lmul <= w_nxt_lmul;
    end
  end

  // Error reporting: one-cycle pulse plus saturating counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_valid <= 1'b0;
      r_err_src   <= SRC_NONE;
      r_err_count <= '0;
    end else begin
      r_err_valid <= w_gnt_illegal;
      r_err_src   <= w_gnt_illegal ? w_gnt : SRC_NONE;
      if (w_gnt_illegal && (r_err_count != '1)) begin
        r_err_count <= r_err_count + ERR_CNT_W'(1);
      end
    end
  end

`ifdef VEC_WB_ARB_RR_EN
  // Round-robin pointer: after a grant the other source is preferred.
  // A mask grant leaves it untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pref_lsu <= 1'b0;
    end else if (w_gnt == SRC_EXE) begin
      r_pref_lsu <= 1'b1;
    end else if (w_gnt == SRC_LSU) begin
      r_pref_lsu <= 1'b0;
    end
  end
`endif

  assign wr_en      = (r_state == WR) & ~r_is_mask;
  assign mask_wr_en = (r_state == WR) &  r_is_mask;
  assign waddr      = r_waddr;
  assign wdata      = r_wdata;
  assign wr_lmul    = r_wr_lmul;
  assign err_valid  = r_err_valid;
  assign err_src    = r_err_src;
  assign err_count  = r_err_count;

endmodule
